// File: rtl/rhd_headstage_emu_array.sv
// Emulates an array of Intan RHD headstage ports driven by one shared SPI master.
// Each port carries one or two dies. Every die answers a command two completed frames later.

module rhd_die #(
  parameter int NUM_CHANNELS = 32,
  parameter int SEED         = 0,
  parameter int PORT         = 0,
  parameter int DIE          = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_done,
  input  logic        i_load,
  input  logic        i_shift,
  input  logic [15:0] i_cmd,
  input  logic [1:0]  i_mode,
  input  logic [15:0] i_sweep,
  input  logic [7:0]  i_reg_rd,
  output logic        o_bit
);
  localparam logic [15:0] SEED_V    = 16'(SEED);
  localparam logic [15:0] LFSR_INIT = SEED_V | 16'h0001;
  localparam logic [7:0]  PORT_V    = 8'(PORT);

  logic [15:0] r_lfsr, r_pipe1, r_pipe2, r_out;
  logic [15:0] w_res;
  logic [7:0]  w_rd;
  logic [5:0]  w_c;
  logic        w_conv, w_fb;

  assign w_c    = i_cmd[13:8];
  assign w_conv = (i_cmd[15:14] == 2'b00);
  assign w_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_comb begin
    w_res = '0;
    w_rd  = '0;
    if (w_conv) begin
      if ({26'd0, w_c} < 32'(NUM_CHANNELS)) begin
        case (i_mode)
          2'b00:   w_res = SEED_V + {10'd0, w_c} + i_sweep;
          2'b01:   w_res = r_lfsr;
          2'b10:   w_res = {PORT_V, 2'b00, w_c};
          default: w_res = '0;
        endcase
      end
    end else if (i_cmd[15:14] == 2'b10) begin
      w_res = {8'hFF, i_cmd[7:0]};
    end else if (i_cmd[15:14] == 2'b11) begin
      case (w_c)
        6'd40:   w_rd = 8'h49;
        6'd41:   w_rd = 8'h4E;
        6'd42:   w_rd = 8'h54;
        6'd43:   w_rd = 8'h41;
        6'd44:   w_rd = 8'h4E;
        6'd60:   w_rd = 8'(DIE);
        6'd63:   w_rd = 8'h01;
        default: w_rd = i_reg_rd;
      endcase
      w_res = {8'h00, w_rd};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr  <= LFSR_INIT;
      r_pipe1 <= '0;
      r_pipe2 <= '0;
      r_out   <= '0;
    end else begin
      if (i_done) begin
        r_pipe2 <= r_pipe1;
        r_pipe1 <= w_res;
        if (w_conv) r_lfsr <= {r_lfsr[14:0], w_fb};
      end
      if (i_load)       r_out <= r_pipe2;
      else if (i_shift) r_out <= {r_out[14:0], 1'b0};
    end
  end

  assign o_bit = r_out[15];
endmodule

module rhd_headstage_emu_array #(
  parameter int NUM_PORTS    = 8,
  parameter int NUM_CHANNELS = 32,
  parameter int SEED_STRIDE  = 8,
  parameter int MISO2_MODE   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 MOSI,
  input  logic                 CS,
  input  logic                 SCLK,
  input  logic [1:0]           pattern_mode,
  output logic [NUM_PORTS-1:0] MISO1,
  output logic [NUM_PORTS-1:0] MISO2,
  output logic [15:0]          frame_count
);
  localparam logic [5:0] LAST_CH = 6'(NUM_CHANNELS - 1);

  logic [1:0]  r_mosi_s, r_cs_s, r_sclk_s;
  logic        r_cs_d, r_sclk_d, r_inframe;
  logic [4:0]  r_bitcnt;
  logic [15:0] r_shift, r_frame_count, r_sweep;
  logic [7:0]  r_regs [32];

  logic        w_cs, w_cs_fall, w_cs_rise, w_sclk_rise, w_sclk_fall, w_done;
  logic [5:0]  w_c;
  logic [7:0]  w_reg_rd;
  logic [NUM_PORTS-1:0] w_b1, w_b2;

  // Syncs reset low so that a CS still low after reset cannot open a frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mosi_s <= '0;
      r_cs_s   <= '0;
      r_sclk_s <= '0;
      r_cs_d   <= 1'b0;
      r_sclk_d <= 1'b0;
    end else begin
      r_mosi_s <= {r_mosi_s[0], MOSI};
      r_cs_s   <= {r_cs_s[0], CS};
      r_sclk_s <= {r_sclk_s[0], SCLK};
      r_cs_d   <= r_cs_s[1];
      r_sclk_d <= r_sclk_s[1];
    end
  end

  assign w_cs        = r_cs_s[1];
  assign w_cs_fall   = ~w_cs & r_cs_d;
  assign w_cs_rise   = w_cs & ~r_cs_d;
  assign w_sclk_rise = r_sclk_s[1] & ~r_sclk_d & ~w_cs & r_inframe;
  assign w_sclk_fall = ~r_sclk_s[1] & r_sclk_d & ~w_cs & r_inframe;
  assign w_done      = w_cs_rise & r_inframe & (r_bitcnt == 5'd16);
  assign w_c         = r_shift[13:8];
  assign w_reg_rd    = (w_c <= 6'd21) ? r_regs[w_c[4:0]] : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inframe     <= 1'b0;
      r_bitcnt      <= '0;
      r_shift       <= '0;
      r_frame_count <= '0;
      r_sweep       <= '0;
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else begin
      if (w_cs_fall) begin
        r_inframe <= 1'b1;
        r_bitcnt  <= '0;
      end else if (w_cs_rise) begin
        r_inframe <= 1'b0;
      end else if (w_sclk_rise) begin
        r_shift <= {r_shift[14:0], r_mosi_s[1]};
        if (r_bitcnt != 5'd16) r_bitcnt <= r_bitcnt + 5'd1;
      end
      if (w_done) begin
        r_frame_count <= r_frame_count + 16'd1;
        if (r_shift == 16'h6A00)
          r_sweep <= '0;
        else if (r_shift[15:14] == 2'b00 && w_c == LAST_CH)
          r_sweep <= r_sweep + 16'd1;
        if (r_shift[15:14] == 2'b10 && w_c <= 6'd21)
          r_regs[w_c[4:0]] <= r_shift[7:0];
      end
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    rhd_die #(.NUM_CHANNELS(NUM_CHANNELS), .SEED(p*SEED_STRIDE), .PORT(p), .DIE(0)) u_die1 (
      .clk(clk), .rst(rst), .i_done(w_done), .i_load(w_cs_fall), .i_shift(w_sclk_fall),
      .i_cmd(r_shift), .i_mode(pattern_mode), .i_sweep(r_sweep), .i_reg_rd(w_reg_rd),
      .o_bit(w_b1[p])
    );
    if (MISO2_MODE == 1) begin : g_die2
      rhd_die #(.NUM_CHANNELS(NUM_CHANNELS), .SEED((p+NUM_PORTS)*SEED_STRIDE), .PORT(p), .DIE(1)) u_die2 (
        .clk(clk), .rst(rst), .i_done(w_done), .i_load(w_cs_fall), .i_shift(w_sclk_fall),
        .i_cmd(r_shift), .i_mode(pattern_mode), .i_sweep(r_sweep), .i_reg_rd(w_reg_rd),
        .o_bit(w_b2[p])
      );
    end else begin : g_inv
      assign w_b2[p] = ~w_b1[p];
    end
  end

  assign MISO1       = {NUM_PORTS{r_inframe}} & w_b1;
  assign MISO2       = {NUM_PORTS{r_inframe}} & w_b2;
  assign frame_count = r_frame_count;
endmodule
